// File: rtl/periodic_trigger_module_pkg.sv
// Shared definitions for the periodic trigger generator: FSM state encoding,
// mode constants and the width of the pulse-width down-counter.
package periodic_trigger_module_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Pulse widths go up to 255 cycles, so eight bits cover the remaining-cycle count.
    localparam int PULSE_CNT_W = 8;

endpackage

// File: rtl/periodic_trigger_module_pulse_stretch.sv
// Turns a single-cycle start strobe into a PULSE_W-cycle registered pulse.
// A synchronous clear kills the pulse immediately and has priority over start.
module pulse_stretch_module
    import periodic_trigger_module_pkg::*;
#(
    parameter int PULSE_W = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_clear,
    output logic o_pulse
);

    localparam logic [PULSE_CNT_W-1:0] REMAIN_INIT = PULSE_CNT_W'(PULSE_W - 1);

    logic [PULSE_CNT_W-1:0] r_remain;
    logic                   r_pulse;

    // Hold the output high for PULSE_W cycles, counting down the cycles still owed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_remain <= '0;
            r_pulse  <= 1'b0;
        end else if (i_clear) begin
            r_remain <= '0;
            r_pulse  <= 1'b0;
        end else if (i_start) begin
            r_remain <= REMAIN_INIT;
            r_pulse  <= 1'b1;
        end else if (r_remain != '0) begin
            r_remain <= r_remain - PULSE_CNT_W'(1);
            r_pulse  <= 1'b1;
        end else begin
            r_pulse  <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/periodic_trigger_module.sv
// Periodic trigger generator: a runtime-loadable period counter driven by an
// IDLE/COUNT/DONE FSM, emitting PULSE_W-wide trigger pulses every P+1 cycles
// (continuous) or once (one-shot), with a saturating emitted-pulse counter.
module periodic_trigger_module
    import periodic_trigger_module_pkg::*;
#(
    parameter int                 CNT_W          = 30,
    parameter logic [CNT_W-1:0]   PERIOD_DEFAULT = CNT_W'(999_999_999),
    parameter int                 PULSE_W        = 1,
    parameter int                 CNT_OUT_W      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    input  logic                 i_mode,
    input  logic [CNT_W-1:0]     i_period_in,
    input  logic                 i_period_load,
    input  logic                 i_restart,
    output logic                 o_trig_en,
    output logic                 o_busy,
    output logic [CNT_OUT_W-1:0] o_trig_count
);

    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(PULSE_W);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_shadow;
    logic [CNT_W-1:0]       r_active;
    logic                   r_mode;
    logic                   r_busy;
    logic [CNT_OUT_W-1:0]   r_trig_count;

    logic [CNT_W-1:0]       w_load_value;
    logic                   w_wrap;
    logic                   w_pulse_start;
    logic                   w_pulse_clear;

    // Periods shorter than the pulse would let pulses overlap, so they are raised to PULSE_W.
    assign w_load_value = (i_period_in < PERIOD_MIN) ? PERIOD_MIN : i_period_in;

    assign w_wrap        = (r_count == r_active);
    assign w_pulse_start = (r_state == ST_COUNT) && i_run && !i_restart && w_wrap;
    assign w_pulse_clear = ((r_state != ST_IDLE) && !i_run) ||
                           ((r_state == ST_COUNT) && i_restart);

    // FSM, period counter, period registers and emitted-pulse counter in one place.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_shadow     <= PERIOD_DEFAULT;
            r_active     <= PERIOD_DEFAULT;
            r_mode       <= MODE_CONT;
            r_busy       <= 1'b0;
            r_trig_count <= '0;
        end else begin
            if (i_period_load) begin
                r_shadow <= w_load_value;
            end
            case (r_state)
                ST_IDLE: begin
                    r_count  <= '0;
                    r_active <= r_shadow;
                    if (i_run) begin
                        r_state      <= ST_COUNT;
                        r_mode       <= i_mode;
                        r_trig_count <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (!i_run) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else if (i_restart) begin
                        r_count <= '0;
                    end else if (w_wrap) begin
                        r_count  <= '0;
                        r_active <= i_period_load ? w_load_value : r_shadow;
                        if (r_trig_count != '1) begin
                            r_trig_count <= r_trig_count + CNT_OUT_W'(1);
                        end
                        if (r_mode == MODE_ONESHOT) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_count <= '0;
                    if (!i_run) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    pulse_stretch_module #(
        .PULSE_W (PULSE_W)
    ) u_pulse_stretch (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_pulse_start),
        .i_clear (w_pulse_clear),
        .o_pulse (o_trig_en)
    );

    assign o_busy       = r_busy;
    assign o_trig_count = r_trig_count;

endmodule

// File: tb/tb_periodic_trigger_module.sv
// Directed bench for the periodic trigger generator with a short period (P=4)
// and two-cycle pulses, plus a second instance with a 2-bit pulse counter.
module tb_periodic_trigger_module;

    logic        clk;
    logic        rstN;
    logic        run;
    logic        mode;
    logic [29:0] periodIn;
    logic        periodLoad;
    logic        restart;

    logic        trigEn;
    logic        busy;
    logic [7:0]  trigCount;
    logic        trigEn2;
    logic        busy2;
    logic [1:0]  trigCount2;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        logic        run;
        logic        mode;
        logic        load;
        logic [29:0] pin;
        logic        restart;
        logic        expTrig;
        logic        expBusy;
        logic [7:0]  expCnt;
    } vec_t;

    vec_t vecs[$];

    periodic_trigger_module #(
        .CNT_W          (30),
        .PERIOD_DEFAULT (30'd4),
        .PULSE_W        (2),
        .CNT_OUT_W      (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_run         (run),
        .i_mode        (mode),
        .i_period_in   (periodIn),
        .i_period_load (periodLoad),
        .i_restart     (restart),
        .o_trig_en     (trigEn),
        .o_busy        (busy),
        .o_trig_count  (trigCount)
    );

    periodic_trigger_module #(
        .CNT_W          (30),
        .PERIOD_DEFAULT (30'd4),
        .PULSE_W        (2),
        .CNT_OUT_W      (2)
    ) dutSat (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_run         (run),
        .i_mode        (mode),
        .i_period_in   (periodIn),
        .i_period_load (periodLoad),
        .i_restart     (restart),
        .o_trig_en     (trigEn2),
        .o_busy        (busy2),
        .o_trig_count  (trigCount2)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something in the sequencing never returns.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic m, input logic ld,
                                 input logic [29:0] p, input logic rs);
        run        = r;
        mode       = m;
        periodLoad = ld;
        periodIn   = p;
        restart    = rs;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic m, input logic ld,
                          input logic [29:0] p, input logic rs,
                          input logic t, input logic b, input logic [7:0] c);
        vec_t v;
        v.run = r; v.mode = m; v.load = ld; v.pin = p; v.restart = rs;
        v.expTrig = t; v.expBusy = b; v.expCnt = c;
        vecs.push_back(v);
    endtask

    task automatic addSpan(input int n, input logic r, input logic m,
                           input logic t, input logic b, input logic [7:0] c);
        for (int k = 0; k < n; k++) addVec(r, m, 1'b0, 30'd0, 1'b0, t, b, c);
    endtask

    // Row i is sampled by rising edge i and its outputs are checked on the following falling edge.
    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].run, vecs[i].mode, vecs[i].load, vecs[i].pin, vecs[i].restart);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("%s[%0d].trig", tag, i + 1), int'(trigEn), int'(vecs[i].expTrig));
            checkOutput($sformatf("%s[%0d].busy", tag, i + 1), int'(busy), int'(vecs[i].expBusy));
            checkOutput($sformatf("%s[%0d].count", tag, i + 1), int'(trigCount), int'(vecs[i].expCnt));
        end
        vecs.delete();
        applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);
    endtask

    task automatic doReset(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput({tag, ".rst.trig"}, int'(trigEn), 0);
        checkOutput({tag, ".rst.busy"}, int'(busy), 0);
        checkOutput({tag, ".rst.count"}, int'(trigCount), 0);
        checkOutput({tag, ".rst.count2"}, int'(trigCount2), 0);
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);

        // Continuous mode: pulses at 6-7, 11-12, 16-17.
        doReset("cont");
        addSpan(5, 1, 0, 0, 1, 0);
        addSpan(2, 1, 0, 1, 1, 1);
        addSpan(3, 1, 0, 0, 1, 1);
        addSpan(2, 1, 0, 1, 1, 2);
        addSpan(3, 1, 0, 0, 1, 2);
        addSpan(2, 1, 0, 1, 1, 3);
        runTable("cont");

        // One-shot: single pulse, DONE, then a fresh run after Run drops for one cycle.
        doReset("oneshot");
        addSpan(5, 1, 1, 0, 1, 0);
        addSpan(2, 1, 1, 1, 0, 1);
        addSpan(3, 1, 1, 0, 0, 1);
        addSpan(1, 0, 1, 0, 0, 1);
        addSpan(1, 1, 1, 0, 1, 0);
        addSpan(4, 1, 1, 0, 1, 0);
        addSpan(1, 1, 1, 1, 0, 1);
        runTable("oneshot");

        // Period load: 9 takes effect after the current period; 0 on a wrap clamps to 2 immediately.
        doReset("load");
        addSpan(2, 1, 0, 0, 1, 0);
        addVec(1, 0, 1, 30'd9, 0, 0, 1, 0);
        addSpan(2, 1, 0, 0, 1, 0);
        addSpan(2, 1, 0, 1, 1, 1);
        addSpan(8, 1, 0, 0, 1, 1);
        addSpan(2, 1, 0, 1, 1, 2);
        addSpan(8, 1, 0, 0, 1, 2);
        addVec(1, 0, 1, 30'd0, 0, 1, 1, 3);
        addSpan(1, 1, 0, 1, 1, 3);
        addSpan(1, 1, 0, 0, 1, 3);
        addSpan(2, 1, 0, 1, 1, 4);
        addSpan(1, 1, 0, 0, 1, 4);
        addSpan(2, 1, 0, 1, 1, 5);
        runTable("load");

        // Restart on the wrap cycle suppresses the pulse; restart during a pulse cuts it.
        doReset("restart");
        addSpan(5, 1, 0, 0, 1, 0);
        addVec(1, 0, 0, 30'd0, 1, 0, 1, 0);
        addSpan(4, 1, 0, 0, 1, 0);
        addSpan(1, 1, 0, 1, 1, 1);
        addVec(1, 0, 0, 30'd0, 1, 0, 1, 1);
        addSpan(4, 1, 0, 0, 1, 1);
        addSpan(2, 1, 0, 1, 1, 2);
        runTable("restart");

        // Run dropped mid-pulse: pulse ends, IDLE, count held.
        doReset("rundrop");
        addSpan(5, 1, 0, 0, 1, 0);
        addSpan(1, 1, 0, 1, 1, 1);
        addSpan(2, 0, 0, 0, 0, 1);
        runTable("rundrop");

        // Asynchronous reset mid-pulse after loading a longer period.
        doReset("async");
        applyStimulus(1'b1, 1'b0, 1'b1, 30'd7, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("async.prePulse", int'(trigEn), 1);
        #2;
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);
        #1;
        checkOutput("async.trig", int'(trigEn), 0);
        checkOutput("async.busy", int'(busy), 0);
        checkOutput("async.count", int'(trigCount), 0);
        @(negedge clk);
        rstN = 1'b1;
        addSpan(5, 1, 0, 0, 1, 0);
        addSpan(2, 1, 0, 1, 1, 1);
        addSpan(1, 1, 0, 0, 1, 1);
        runTable("async");

        // Saturation: 2-bit counter reads 1,2,3,3,3 while the 8-bit one keeps counting.
        doReset("sat");
        applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc >= 6 && (cyc - 6) % 5 == 0) begin
                checkOutput($sformatf("sat.c%0d.count2", cyc), int'(trigCount2),
                            ((cyc - 1) / 5 > 3) ? 3 : (cyc - 1) / 5);
                checkOutput($sformatf("sat.c%0d.count", cyc), int'(trigCount), (cyc - 1) / 5);
                checkOutput($sformatf("sat.c%0d.trig2", cyc), int'(trigEn2), 1);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
